// File: rtl/head_group_link_pkg.sv
// Shared types for the head group vlink router and its finish tracker.
`ifndef HEAD_CORE_NUM
`define HEAD_CORE_NUM 4
`endif
`ifndef MAC_MULT_NUM
`define MAC_MULT_NUM 4
`endif
`ifndef IDATA_WIDTH
`define IDATA_WIDTH 8
`endif

package head_group_link_pkg;

  typedef enum logic [1:0] {
    PAIR_SWAP = 2'd0,
    RING      = 2'd1,
    BCAST     = 2'd2,
    OFF       = 2'd3
  } link_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } control_state_e;

  typedef struct packed {
    link_mode_e mode;
  } op_config_t;

  // Source head feeding destination head h under mode m in a group of n heads.
  function automatic int unsigned src_head(link_mode_e m, int unsigned h, int unsigned n);
    case (m)
      PAIR_SWAP: return h ^ 1;
      RING:      return (h + n - 1) % n;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/head_finish_tracker.sv
// Tracks per-head finish pulses for one operation; flags protocol errors and timeout.
module head_finish_tracker
  import head_group_link_pkg::*;
#(
  parameter int unsigned HEAD_NUM    = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode_req,
  input  logic [HEAD_NUM-1:0] head_en,
  input  logic [HEAD_NUM-1:0] finish_in,
  output logic                idle,
  output logic                busy,
  output logic                all_finish,
  output logic                finish_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  control_state_e      state;
  logic [HEAD_NUM-1:0] pending;
  logic [HEAD_NUM-1:0] start_mask;
  logic [HEAD_NUM-1:0] pend_clr;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic                err;

  always_comb begin
    start_mask = head_en & ~finish_in;
    pend_clr   = pending & ~finish_in;
    cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    err        = mode_req && (state != IDLE);
    case (state)
      IDLE:    if (!start && (|finish_in)) err = 1'b1;
      RUN:     if (start || (|(finish_in & ~pending))) err = 1'b1;
      DONE:    if (start || (|finish_in)) err = 1'b1;
      default: ;
    endcase
  end

  assign idle = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      all_finish <= 1'b0;
      finish_err <= 1'b0;
    end else begin
      all_finish <= 1'b0;
      finish_err <= err;
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= '0;
            pending <= start_mask;
            if (start_mask == '0) begin
              state      <= DONE;
              all_finish <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          cnt     <= cnt_inc;
          pending <= pend_clr;
          // Completion on the final cycle wins over a coincident timeout.
          if (pend_clr == '0) begin
            state      <= DONE;
            busy       <= 1'b0;
            all_finish <= 1'b1;
          end else if (cnt_inc == CNT_MAX) begin
            state      <= IDLE;
            busy       <= 1'b0;
            pending    <= '0;
            finish_err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/head_group_link.sv
// Registered vlink crossbar between the heads of a group plus the finish tracker.
`ifndef HEAD_CORE_NUM
`define HEAD_CORE_NUM 4
`endif
`ifndef MAC_MULT_NUM
`define MAC_MULT_NUM 4
`endif
`ifndef IDATA_WIDTH
`define IDATA_WIDTH 8
`endif

module head_group_link
  import head_group_link_pkg::*;
#(
  parameter int unsigned HEAD_NUM         = 4,
  parameter int unsigned LANE_NUM         = `HEAD_CORE_NUM,
  parameter int unsigned VLINK_DATA_WIDTH = (`MAC_MULT_NUM * `IDATA_WIDTH),
  parameter int unsigned TIMEOUT_CYC      = 65535
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 link_mode_vld,
  input  logic [1:0]                                           link_mode,
  input  logic [HEAD_NUM-1:0]                                  head_en,
  input  logic [HEAD_NUM-1:0][LANE_NUM-1:0][VLINK_DATA_WIDTH-1:0] vlink_src_array,
  input  logic [HEAD_NUM-1:0][LANE_NUM-1:0]                    vlink_src_vld_array,
  output logic [HEAD_NUM-1:0][LANE_NUM-1:0][VLINK_DATA_WIDTH-1:0] vlink_dst_array,
  output logic [HEAD_NUM-1:0][LANE_NUM-1:0]                    vlink_dst_vld_array,
  input  logic                                                 start,
  input  logic [HEAD_NUM-1:0]                                  finish_in,
  output logic                                                 all_finish,
  output logic                                                 finish_err,
  output logic                                                 busy
);

  localparam int unsigned HW = $clog2(HEAD_NUM);

  op_config_t                               cfg;
  logic                                     idle;
  logic [HEAD_NUM-1:0][HW-1:0]              src_sel;
  logic [HEAD_NUM-1:0]                      route_ok;
  logic [HEAD_NUM-1:0][LANE_NUM-1:0]        gated_vld;

  head_finish_tracker #(
    .HEAD_NUM    (HEAD_NUM),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode_req   (link_mode_vld),
    .head_en    (head_en),
    .finish_in  (finish_in),
    .idle       (idle),
    .busy       (busy),
    .all_finish (all_finish),
    .finish_err (finish_err)
  );

  always_comb begin
    src_sel   = '0;
    route_ok  = '0;
    gated_vld = '0;
    for (int unsigned h = 0; h < HEAD_NUM; h++) begin
      src_sel[h]   = HW'(src_head(cfg.mode, h, HEAD_NUM));
      // Broadcast never loops head 0 back onto itself.
      route_ok[h]  = (cfg.mode != OFF) && !((cfg.mode == BCAST) && (h == 0)) &&
                     head_en[src_sel[h]] && head_en[h];
      gated_vld[h] = {LANE_NUM{route_ok[h]}} & vlink_src_vld_array[src_sel[h]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg                 <= '{mode: OFF};
      vlink_dst_vld_array <= '0;
      vlink_dst_array     <= '0;
    end else begin
      if (link_mode_vld && idle) cfg.mode <= link_mode_e'(link_mode);
      vlink_dst_vld_array <= gated_vld;
      for (int unsigned h = 0; h < HEAD_NUM; h++) begin
        for (int unsigned l = 0; l < LANE_NUM; l++) begin
          if (gated_vld[h][l]) vlink_dst_array[h][l] <= vlink_src_array[src_sel[h]][l];
        end
      end
    end
  end

endmodule
